// File: rtl/mul_man_pipe.sv
// Pipelined mantissa multiplier for the FPU multiply datapath.
// Operand stage -> PROD_STAGES product stages -> round/normalise output stage.
// Each stage has a valid bit. A stage may load when it is empty or when the stage after it
// is advancing, so bubbles collapse and a stall holds every stage in place.
module mul_man_pipe #(
    parameter int unsigned MAN_W       = 24,
    parameter int unsigned PROD_STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [MAN_W-1:0] i_data_a,
    input  logic [MAN_W-1:0] i_data_b,
    input  logic             i_sign,
    input  logic [1:0]       i_rmode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [MAN_W-1:0] o_data_mul,
    output logic [1:0]       o_exp_inc,
    output logic             o_inexact,
    output logic             o_zero
);

    localparam int unsigned PW   = 2 * MAN_W;
    localparam int unsigned LAST = PROD_STAGES - 1;

    typedef enum logic [1:0] {
        RmRne = 2'b00,
        RmRtz = 2'b01,
        RmRup = 2'b10,
        RmRdn = 2'b11
    } rmode_e;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic             in_v_q, in_v_d;
    logic [MAN_W-1:0] in_a_q, in_a_d;
    logic [MAN_W-1:0] in_b_q, in_b_d;
    logic             in_sign_q, in_sign_d;
    rmode_e           in_rmode_q, in_rmode_d;

    logic [PROD_STAGES-1:0] p_v_q, p_v_d;
    logic [PW-1:0]          p_prod_q [PROD_STAGES];
    logic [PW-1:0]          p_prod_d [PROD_STAGES];
    logic [PROD_STAGES-1:0] p_sign_q, p_sign_d;
    rmode_e                 p_rmode_q [PROD_STAGES];
    rmode_e                 p_rmode_d [PROD_STAGES];

    logic             out_v_q, out_v_d;
    logic [MAN_W-1:0] out_mul_q, out_mul_d;
    logic [1:0]       out_exp_q, out_exp_d;
    logic             out_inexact_q, out_inexact_d;
    logic             out_zero_q, out_zero_d;

    // ------------------------------------------------------------------
    // Ready chain
    // ------------------------------------------------------------------
    logic                   out_rdy;
    logic [PROD_STAGES-1:0] p_rdy;
    logic                   in_rdy;

    assign out_rdy = ~out_v_q | i_ready;

    // rdy_k = ~v_k | rdy_{k+1} unrolled: a stage can load unless it and every stage after it
    // is full while the output is stalled. Written flat so there is no combinational loop
    // through the vector.
    for (genvar k = 0; k < PROD_STAGES; k++) begin : g_p_rdy
        assign p_rdy[k] = out_rdy | ~(&p_v_q[PROD_STAGES-1:k]);
    end

    assign in_rdy  = ~in_v_q | p_rdy[0];
    assign o_ready = in_rdy;

    // ------------------------------------------------------------------
    // Operand stage
    // ------------------------------------------------------------------
    // Capture operands on transfer-in; an empty slot is written when no operand arrives.
    always_comb begin
        in_v_d     = in_v_q;
        in_a_d     = in_a_q;
        in_b_d     = in_b_q;
        in_sign_d  = in_sign_q;
        in_rmode_d = in_rmode_q;
        if (in_rdy) begin
            in_v_d = i_valid;
            if (i_valid) begin
                in_a_d     = i_data_a;
                in_b_d     = i_data_b;
                in_sign_d  = i_sign;
                in_rmode_d = rmode_e'(i_rmode);
            end
        end
    end

    // Operand stage registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_v_q     <= 1'b0;
            in_a_q     <= '0;
            in_b_q     <= '0;
            in_sign_q  <= 1'b0;
            in_rmode_q <= RmRne;
        end else begin
            in_v_q     <= in_v_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            in_sign_q  <= in_sign_d;
            in_rmode_q <= in_rmode_d;
        end
    end

    // ------------------------------------------------------------------
    // Product stages
    // ------------------------------------------------------------------
    logic [PW-1:0] prod;

    assign prod = {{MAN_W{1'b0}}, in_a_q} * {{MAN_W{1'b0}}, in_b_q};

    // First product stage multiplies; later stages are plain copies that only give the
    // multiplier more register slack.
    always_comb begin
        p_v_d    = p_v_q;
        p_sign_d = p_sign_q;
        for (int k = 0; k < PROD_STAGES; k++) begin
            p_prod_d[k]  = p_prod_q[k];
            p_rmode_d[k] = p_rmode_q[k];
        end

        if (p_rdy[0]) begin
            p_v_d[0] = in_v_q;
            if (in_v_q) begin
                p_prod_d[0]  = prod;
                p_sign_d[0]  = in_sign_q;
                p_rmode_d[0] = in_rmode_q;
            end
        end

        for (int k = 1; k < PROD_STAGES; k++) begin
            if (p_rdy[k]) begin
                p_v_d[k] = p_v_q[k-1];
                if (p_v_q[k-1]) begin
                    p_prod_d[k]  = p_prod_q[k-1];
                    p_sign_d[k]  = p_sign_q[k-1];
                    p_rmode_d[k] = p_rmode_q[k-1];
                end
            end
        end
    end

    // Product stage registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p_v_q    <= '0;
            p_sign_q <= '0;
            for (int k = 0; k < PROD_STAGES; k++) begin
                p_prod_q[k]  <= '0;
                p_rmode_q[k] <= RmRne;
            end
        end else begin
            p_v_q    <= p_v_d;
            p_sign_q <= p_sign_d;
            for (int k = 0; k < PROD_STAGES; k++) begin
                p_prod_q[k]  <= p_prod_d[k];
                p_rmode_q[k] <= p_rmode_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Normalise and round (feeds the output stage)
    // ------------------------------------------------------------------
    logic [PW-1:0]    lp;
    logic             norm;
    logic [MAN_W-1:0] kept;
    logic             g_bit, r_bit, s_bit;
    logic             inc;
    logic [MAN_W:0]   rounded;
    logic             carry;
    logic [MAN_W-1:0] rnd_mul;
    logic [1:0]       rnd_exp;
    logic             rnd_inexact;
    logic             rnd_zero;

    assign lp = p_prod_q[LAST];

    // Pick the kept field and guard/round/sticky bits from the leading-one position, then
    // apply the selected rounding increment.
    always_comb begin
        norm = lp[PW-1];
        if (norm) begin
            kept  = lp[PW-1:MAN_W];
            g_bit = lp[MAN_W-1];
            r_bit = lp[MAN_W-2];
            s_bit = |lp[MAN_W-3:0];
        end else begin
            kept  = lp[PW-2:MAN_W-1];
            g_bit = lp[MAN_W-2];
            r_bit = lp[MAN_W-3];
            s_bit = |lp[MAN_W-4:0];
        end

        inc = 1'b0;
        unique case (p_rmode_q[LAST])
            RmRne: inc = g_bit & (r_bit | s_bit | kept[0]);
            RmRtz: inc = 1'b0;
            RmRup: inc = ~p_sign_q[LAST] & (g_bit | r_bit | s_bit);
            RmRdn: inc = p_sign_q[LAST] & (g_bit | r_bit | s_bit);
        endcase

        rounded = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
        carry   = rounded[MAN_W];
        // A rounding carry only happens from all-ones, so the shifted result is exactly 1.0.
        rnd_mul     = carry ? {1'b1, {(MAN_W-1){1'b0}}} : rounded[MAN_W-1:0];
        rnd_exp     = {1'b0, norm} + {1'b0, carry};
        rnd_inexact = g_bit | r_bit | s_bit;
        rnd_zero    = (lp == '0);

        if (rnd_zero) begin
            rnd_mul     = '0;
            rnd_exp     = 2'd0;
            rnd_inexact = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Result fields only change when a new result lands, so they hold while o_valid is low.
    always_comb begin
        out_v_d       = out_v_q;
        out_mul_d     = out_mul_q;
        out_exp_d     = out_exp_q;
        out_inexact_d = out_inexact_q;
        out_zero_d    = out_zero_q;
        if (out_rdy) begin
            out_v_d = p_v_q[LAST];
            if (p_v_q[LAST]) begin
                out_mul_d     = rnd_mul;
                out_exp_d     = rnd_exp;
                out_inexact_d = rnd_inexact;
                out_zero_d    = rnd_zero;
            end
        end
    end

    // Output stage registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_v_q       <= 1'b0;
            out_mul_q     <= '0;
            out_exp_q     <= 2'd0;
            out_inexact_q <= 1'b0;
            out_zero_q    <= 1'b0;
        end else begin
            out_v_q       <= out_v_d;
            out_mul_q     <= out_mul_d;
            out_exp_q     <= out_exp_d;
            out_inexact_q <= out_inexact_d;
            out_zero_q    <= out_zero_d;
        end
    end

    assign o_valid    = out_v_q;
    assign o_data_mul = out_mul_q;
    assign o_exp_inc  = out_exp_q;
    assign o_inexact  = out_inexact_q;
    assign o_zero     = out_zero_q;

endmodule

// File: tb/tb_mul_man_pipe.sv
// Directed bench for mul_man_pipe (MAN_W=24) with a second PROD_STAGES=4 instance.
module tb_mul_man_pipe;

    typedef struct packed {
        logic [23:0] a;
        logic [23:0] b;
        logic        sign;
        logic [1:0]  rm;
        logic [23:0] mul;
        logic [1:0]  exp;
        logic        inx;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_valid, i_ready, i_sign;
    logic [1:0]  i_rmode;
    logic [23:0] i_a, i_b;
    logic        o_ready, o_valid, o_inexact, o_zero;
    logic [23:0] o_mul;
    logic [1:0]  o_exp;

    logic        v4;
    logic        r4_ready, r4_valid, r4_inexact, r4_zero;
    logic [23:0] r4_mul;
    logic [1:0]  r4_exp;

    int   n_run  = 0;
    int   n_fail = 0;
    vec_t vt [14];

    mul_man_pipe #(.MAN_W(24), .PROD_STAGES(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_a), .i_data_b(i_b), .i_sign(i_sign), .i_rmode(i_rmode),
        .o_valid(o_valid), .i_ready(i_ready), .o_data_mul(o_mul), .o_exp_inc(o_exp),
        .o_inexact(o_inexact), .o_zero(o_zero)
    );

    mul_man_pipe #(.MAN_W(24), .PROD_STAGES(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(r4_ready),
        .i_data_a(i_a), .i_data_b(i_b), .i_sign(i_sign), .i_rmode(i_rmode),
        .o_valid(r4_valid), .i_ready(1'b1), .o_data_mul(r4_mul), .o_exp_inc(r4_exp),
        .o_inexact(r4_inexact), .o_zero(r4_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx);
        i_a     = vt[idx].a;
        i_b     = vt[idx].b;
        i_sign  = vt[idx].sign;
        i_rmode = vt[idx].rm;
    endtask

    task automatic check_out(input string tag, input int idx);
        check({tag, "_mul"}, {8'd0, o_mul}, {8'd0, vt[idx].mul});
        check({tag, "_exp"}, {30'd0, o_exp}, {30'd0, vt[idx].exp});
        check({tag, "_inexact"}, {31'd0, o_inexact}, {31'd0, vt[idx].inx});
        check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, vt[idx].zero});
    endtask

    // One isolated operation: measure latency, check result, then check retire and hold.
    task automatic single(input int idx);
        int lat;
        lat = 0;
        @(negedge clk);
        drive(idx);
        i_valid = 1'b1;
        #1 check("single_accept", {31'd0, o_ready}, 32'd1);
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            if (lat == 0) i_valid = 1'b0;
            lat++;
        end
        check("single_latency", lat, 32'd3);
        check_out($sformatf("single%0d", idx), idx);
        @(posedge clk);
        #1;
        check("single_retire", {31'd0, o_valid}, 32'd0);
        check("single_hold", {8'd0, o_mul}, {8'd0, vt[idx].mul});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int in_idx, out_idx, inflight, cyc, stale, lat;
        logic saw_stall;

        // a, b, sign, rmode -> mul, exp_inc, inexact, zero  (rmode 0 RNE 1 RTZ 2 RUP 3 RDN)
        vt[0]  = '{24'h800000, 24'h800000, 1'b0, 2'd0, 24'h800000, 2'd0, 1'b0, 1'b0};
        vt[1]  = '{24'hC00000, 24'hC00000, 1'b0, 2'd0, 24'h900000, 2'd1, 1'b0, 1'b0};
        vt[2]  = '{24'hB504F3, 24'hB504F3, 1'b0, 2'd0, 24'hFFFFFF, 2'd0, 1'b1, 1'b0};
        vt[3]  = '{24'hB504F3, 24'hB504F3, 1'b0, 2'd2, 24'h800000, 2'd1, 1'b1, 1'b0};
        vt[4]  = '{24'hB504F3, 24'hB504F3, 1'b1, 2'd3, 24'h800000, 2'd1, 1'b1, 1'b0};
        vt[5]  = '{24'hB504F3, 24'hB504F3, 1'b0, 2'd3, 24'hFFFFFF, 2'd0, 1'b1, 1'b0};
        vt[6]  = '{24'hFFFFFF, 24'h800001, 1'b0, 2'd0, 24'h800000, 2'd1, 1'b1, 1'b0};
        vt[7]  = '{24'hFFFFFF, 24'h800001, 1'b0, 2'd2, 24'h800001, 2'd1, 1'b1, 1'b0};
        vt[8]  = '{24'h800001, 24'hC00000, 1'b0, 2'd0, 24'hC00002, 2'd0, 1'b1, 1'b0};
        vt[9]  = '{24'h800001, 24'hC00000, 1'b0, 2'd1, 24'hC00001, 2'd0, 1'b1, 1'b0};
        vt[10] = '{24'h000000, 24'hC00000, 1'b0, 2'd2, 24'h000000, 2'd0, 1'b0, 1'b1};
        vt[11] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 2'd2, 24'hFFFFFF, 2'd1, 1'b1, 1'b0};
        vt[12] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'd2, 24'hFFFFFE, 2'd1, 1'b1, 1'b0};
        vt[13] = '{24'hB504F3, 24'hB504F3, 1'b1, 2'd1, 24'hFFFFFF, 2'd0, 1'b1, 1'b0};

        rst = 1'b1; i_valid = 1'b0; v4 = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_sign = 1'b0; i_rmode = 2'd0;
        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_mul", {8'd0, o_mul}, 32'd0);
        check("rst_exp", {30'd0, o_exp}, 32'd0);
        check("rst_inexact", {31'd0, o_inexact}, 32'd0);
        check("rst_zero", {31'd0, o_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_ready", {31'd0, o_ready}, 32'd1);

        for (int i = 0; i < 14; i++) single(i);

        // Streaming: 8 back-to-back ops, output stalled in cycles 3..6.
        in_idx = 0; out_idx = 0; inflight = 0; cyc = 0; saw_stall = 1'b0;
        while (out_idx < 8 && cyc < 60) begin
            @(negedge clk);
            i_ready = !(cyc >= 3 && cyc <= 6);
            if (in_idx < 8) begin
                drive(6 + in_idx);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (!o_ready) begin
                saw_stall = 1'b1;
                check("stall_full", inflight, 32'd3);
            end
            if (o_valid && i_ready) begin
                check_out($sformatf("stream%0d", out_idx), 6 + out_idx);
                out_idx++;
                inflight--;
            end
            if (i_valid && o_ready) begin
                in_idx++;
                inflight++;
            end
            cyc++;
        end
        check("stream_count", out_idx, 32'd8);
        check("stream_stall_seen", {31'd0, saw_stall}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        stale = 0;
        repeat (4) begin
            #1 if (o_valid) stale++;
            @(negedge clk);
        end
        check("stream_no_dup", stale, 32'd0);

        // Reset with three ops held in a stalled pipe.
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i);
            i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        #1 check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_mul", {8'd0, o_mul}, 32'd0);
        check("midrst_exp", {30'd0, o_exp}, 32'd0);
        check("midrst_inexact", {31'd0, o_inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        #1 check("midrst_ready", {31'd0, o_ready}, 32'd1);
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (o_valid) stale++;
        end
        check("midrst_no_stale", stale, 32'd0);
        single(1);

        // Four product stages: latency 6.
        @(negedge clk);
        drive(0);
        v4 = 1'b1;
        lat = 0;
        #1 check("ps4_ready", {31'd0, r4_ready}, 32'd1);
        while (!r4_valid && lat < 30) begin
            @(posedge clk);
            #1;
            if (lat == 0) v4 = 1'b0;
            lat++;
        end
        check("ps4_latency", lat, 32'd6);
        check("ps4_mul", {8'd0, r4_mul}, 32'h800000);
        check("ps4_exp", {30'd0, r4_exp}, 32'd0);
        check("ps4_inexact", {31'd0, r4_inexact}, 32'd0);
        check("ps4_zero", {31'd0, r4_zero}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
